// File: rtl/pad_in_filter_if.sv
// Pad input bus between the padring and the pad_in_filter conditioning stage.
// The master drives raw pads and filter controls; the slave returns clean levels and edge strobes.
interface pad_in_filter_if #(
  parameter int NPads    = 70,
  parameter int FiltCntW = 4
);
  logic [NPads-1:0]    pad_in_i;
  logic [NPads-1:0]    filt_en_i;
  logic [FiltCntW-1:0] filt_thresh_i;
  logic [NPads-1:0]    pad_in_o;
  logic [NPads-1:0]    edge_rise_o;
  logic [NPads-1:0]    edge_fall_o;

  modport master (
    output pad_in_i, filt_en_i, filt_thresh_i,
    input  pad_in_o, edge_rise_o, edge_fall_o
  );

  modport slave (
    input  pad_in_i, filt_en_i, filt_thresh_i,
    output pad_in_o, edge_rise_o, edge_fall_o
  );
endinterface

// File: rtl/pad_in_filter.sv
// Per-pad two-flop synchroniser, optional stability-count deglitch, and edge strobes.
// Edge strobe registers exist only when SUNBURST_PAD_FILTER_EDGE_EN is defined; otherwise strobes are tied low.
module pad_in_filter #(
  parameter int               NPads    = 70,
  parameter int               FiltCntW = 4,
  parameter logic [NPads-1:0] ResetVal = '0
) (
  input logic              clk_peri_i,
  input logic              rst_peri_ni,
  pad_in_filter_if.slave   bus
);

  logic [NPads-1:0]    s1_q;
  logic [NPads-1:0]    s2_q;
  logic [NPads-1:0]    st_q;
  logic [NPads-1:0]    st_d;
  logic [FiltCntW-1:0] cnt_q [NPads];
  logic [FiltCntW-1:0] cnt_d [NPads];

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NPads; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = '0;
      if (!bus.filt_en_i[i]) begin
        st_d[i] = s2_q[i];
      end else if (s2_q[i] != st_q[i]) begin
        // One extra bit keeps cnt+1 from wrapping against the threshold.
        if (({1'b0, cnt_q[i]} + (FiltCntW+1)'(1)) >= {1'b0, bus.filt_thresh_i}) begin
          st_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + FiltCntW'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_peri_i or negedge rst_peri_ni) begin
    if (!rst_peri_ni) begin
      s1_q <= ResetVal;
      s2_q <= ResetVal;
      st_q <= ResetVal;
      // NOTE: the counter array is a bank of flops, not a RAM, so it is reset like any register.
      for (int i = 0; i < NPads; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q <= bus.pad_in_i;
      s2_q <= s1_q;
      st_q <= st_d;
      for (int i = 0; i < NPads; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.pad_in_o = st_q;

`ifdef SUNBURST_PAD_FILTER_EDGE_EN
  logic [NPads-1:0] rise_q;
  logic [NPads-1:0] fall_q;

  // Strobes are taken from st_d so they line up with the cycle pad_in_o changes.
  always_ff @(posedge clk_peri_i or negedge rst_peri_ni) begin
    if (!rst_peri_ni) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= ~st_q & st_d;
      fall_q <= st_q & ~st_d;
    end
  end

  assign bus.edge_rise_o = rise_q;
  assign bus.edge_fall_o = fall_q;
`else
  assign bus.edge_rise_o = '0;
  assign bus.edge_fall_o = '0;
`endif

endmodule

// File: tb/tb_pad_in_filter.sv
// Directed bench for pad_in_filter: reset, bypass, deglitch, threshold/enable changes, mid-run reset.
// Strobe expectations follow whether SUNBURST_PAD_FILTER_EDGE_EN is defined for the build.
module tb_pad_in_filter;

  localparam int NP = 70;
  localparam int CW = 4;
`ifdef SUNBURST_PAD_FILTER_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  pad_in_filter_if #(.NPads(NP), .FiltCntW(CW)) pin ();

  pad_in_filter #(
    .NPads   (NP),
    .FiltCntW(CW),
    .ResetVal(70'h1)
  ) dut (
    .clk_peri_i (clk),
    .rst_peri_ni(rst_n),
    .bus        (pin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NP-1:0] bit_at(input int i);
    logic [NP-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NP-1:0] ex(input logic [NP-1:0] v);
    return EdgeEn ? v : '0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    pin.pad_in_i      = '0;
    pin.filt_en_i     = '0;
    pin.filt_thresh_i = '0;

    // Reset held, then released with all pads at 0 against ResetVal bit 0 = 1
    tick(); tick();
    check("rst_lvl",  pin.pad_in_o,    70'h1);
    check("rst_rise", pin.edge_rise_o, '0);
    check("rst_fall", pin.edge_fall_o, '0);
    rst_n = 1'b1;
    tick();
    check("rel_e0_lvl",  pin.pad_in_o,    70'h1);
    check("rel_e0_fall", pin.edge_fall_o, '0);
    check("rel_e0_rise", pin.edge_rise_o, '0);
    tick();
    check("rel_e1_lvl",  pin.pad_in_o,    70'h1);
    check("rel_e1_fall", pin.edge_fall_o, '0);
    tick();
    check("rel_e2_lvl",  pin.pad_in_o,    '0);
    check("rel_e2_fall", pin.edge_fall_o, ex(70'h1));
    check("rel_e2_rise", pin.edge_rise_o, '0);
    tick();
    check("rel_e3_fall", pin.edge_fall_o, '0);

    // Bypass, pad 5 rise then fall
    pin.pad_in_i[5] = 1'b1;
    tick(); check("p5_e0", pin.pad_in_o, '0);
    tick(); check("p5_e1", pin.pad_in_o, '0);
    tick();
    check("p5_e2",      pin.pad_in_o,    bit_at(5));
    check("p5_e2_rise", pin.edge_rise_o, ex(bit_at(5)));
    tick();
    check("p5_e3",      pin.pad_in_o,    bit_at(5));
    check("p5_e3_rise", pin.edge_rise_o, '0);
    pin.pad_in_i[5] = 1'b0;
    tick(); tick();
    check("p5_f_e1", pin.pad_in_o, bit_at(5));
    tick();
    check("p5_f_e2",      pin.pad_in_o,    '0);
    check("p5_f_e2_fall", pin.edge_fall_o, ex(bit_at(5)));
    tick();
    check("p5_f_e3_fall", pin.edge_fall_o, '0);

    // Bypass, pad 40 two-cycle pulse
    pin.pad_in_i[40] = 1'b1;
    tick(); check("p40_e0", pin.pad_in_o, '0);
    tick(); check("p40_e1", pin.pad_in_o, '0);
    pin.pad_in_i[40] = 1'b0;
    tick();
    check("p40_e2",      pin.pad_in_o,    bit_at(40));
    check("p40_e2_rise", pin.edge_rise_o, ex(bit_at(40)));
    tick();
    check("p40_e3",      pin.pad_in_o,    bit_at(40));
    check("p40_e3_rise", pin.edge_rise_o, '0);
    tick();
    check("p40_e4",      pin.pad_in_o,    '0);
    check("p40_e4_fall", pin.edge_fall_o, ex(bit_at(40)));
    tick();
    check("p40_e5_fall", pin.edge_fall_o, '0);

    // Filter T=4, pad 10: 3-cycle glitch is rejected
    pin.filt_en_i[10]  = 1'b1;
    pin.filt_thresh_i  = 4'd4;
    pin.pad_in_i[10]   = 1'b1;
    tick(); tick(); tick();
    pin.pad_in_i[10] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("p10_glitch_lvl%0d", k),  pin.pad_in_o,    '0);
      check($sformatf("p10_glitch_rise%0d", k), pin.edge_rise_o, '0);
    end

    // Filter T=4, pad 10: 4-cycle pulse passes, then the low level passes after 2+T edges
    pin.pad_in_i[10] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("p10_hi_e%0d", k), pin.pad_in_o, '0);
    end
    pin.pad_in_i[10] = 1'b0;
    tick(); check("p10_e4", pin.pad_in_o, '0);
    tick();
    check("p10_e5",      pin.pad_in_o,    bit_at(10));
    check("p10_e5_rise", pin.edge_rise_o, ex(bit_at(10)));
    for (int k = 6; k < 9; k++) begin
      tick();
      check($sformatf("p10_e%0d", k), pin.pad_in_o, bit_at(10));
    end
    tick();
    check("p10_e9",      pin.pad_in_o,    '0);
    check("p10_e9_fall", pin.edge_fall_o, ex(bit_at(10)));
    tick();
    check("p10_e10_fall", pin.edge_fall_o, '0);

    // Threshold lowered 8 -> 2 while pad 20 counts at 5
    pin.filt_en_i[20] = 1'b1;
    pin.filt_thresh_i = 4'd8;
    pin.pad_in_i[20]  = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("p20_e%0d", k), pin.pad_in_o, '0);
    end
    check("p20_cnt5", 70'(dut.cnt_q[20]), 70'd5);
    pin.filt_thresh_i = 4'd2;
    tick();
    check("p20_e7",      pin.pad_in_o,    bit_at(20));
    check("p20_e7_rise", pin.edge_rise_o, ex(bit_at(20)));
    check("p20_cnt0",    70'(dut.cnt_q[20]), '0);

    // Enable cleared on pad 30 with T=6 and cnt=3
    pin.filt_en_i[30] = 1'b1;
    pin.filt_thresh_i = 4'd6;
    pin.pad_in_i[30]  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("p30_e%0d", k), pin.pad_in_o[30], 1'b0);
    end
    check("p30_cnt3", 70'(dut.cnt_q[30]), 70'd3);
    pin.filt_en_i[30] = 1'b0;
    tick();
    check("p30_e5",      pin.pad_in_o,    bit_at(20) | bit_at(30));
    check("p30_e5_rise", pin.edge_rise_o, ex(bit_at(30)));
    check("p30_e5_fall", pin.edge_fall_o, '0);
    check("p30_cnt0",    70'(dut.cnt_q[30]), '0);
    for (int k = 6; k < 9; k++) begin
      tick();
      check($sformatf("p30_e%0d_rise", k), pin.edge_rise_o, '0);
      check($sformatf("p30_e%0d_fall", k), pin.edge_fall_o, '0);
    end

    // T=1 and T=0 follow bypass timing, pad 50
    pin.filt_en_i[50] = 1'b1;
    pin.filt_thresh_i = 4'd1;
    pin.pad_in_i[50]  = 1'b1;
    tick(); tick();
    check("p50_t1_e1", pin.pad_in_o[50], 1'b0);
    tick();
    check("p50_t1_e2",      pin.pad_in_o[50], 1'b1);
    check("p50_t1_e2_rise", pin.edge_rise_o,  ex(bit_at(50)));
    pin.filt_thresh_i = 4'd0;
    pin.pad_in_i[50]  = 1'b0;
    tick(); tick();
    check("p50_t0_e1", pin.pad_in_o[50], 1'b1);
    tick();
    check("p50_t0_e2",      pin.pad_in_o,    bit_at(20) | bit_at(30));
    check("p50_t0_e2_fall", pin.edge_fall_o, ex(bit_at(50)));

    // Reset mid-operation, with pad 7 high on release
    pin.filt_en_i = '0;
    pin.pad_in_i  = bit_at(7);
    tick(); tick(); tick();
    check("pre_rst_lvl",  pin.pad_in_o,    bit_at(7));
    check("pre_rst_rise", pin.edge_rise_o, ex(bit_at(7)));
    check("pre_rst_fall", pin.edge_fall_o, ex(bit_at(20) | bit_at(30)));
    rst_n = 1'b0;
    #1;
    check("mid_rst_async_lvl",  pin.pad_in_o,    70'h1);
    check("mid_rst_async_rise", pin.edge_rise_o, '0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rel2_e0_lvl",  pin.pad_in_o,    70'h1);
    check("rel2_e0_rise", pin.edge_rise_o, '0);
    check("rel2_e0_fall", pin.edge_fall_o, '0);
    tick();
    check("rel2_e1_lvl",  pin.pad_in_o,    70'h1);
    check("rel2_e1_rise", pin.edge_rise_o, '0);
    tick();
    check("rel2_e2_lvl",  pin.pad_in_o,    bit_at(7));
    check("rel2_e2_rise", pin.edge_rise_o, ex(bit_at(7)));
    check("rel2_e2_fall", pin.edge_fall_o, ex(70'h1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
